mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 34 +++
 rtl/mem_access_unit_if.sv | 47 ++++
 rtl/access_timer.sv | 36 +++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared FSM encoding, IR reset value and instruction fields
//               for the memory access unit.
// Revision    : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // All-zero word decodes as sll r0,r0,0, which is a nop.
    localparam logic [31:0] C_IR_RESET = 32'h0000_0000;

    localparam int C_OPCODE_MSB = 31;
    localparam int C_OPCODE_LSB = 26;
    localparam int C_FUNCT_MSB  = 5;
    localparam int C_FUNCT_LSB  = 0;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[C_OPCODE_MSB:C_OPCODE_LSB];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[C_FUNCT_MSB:C_FUNCT_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Controller controls, single-port req/ack memory bus and
//               instruction/data register outputs of the memory access unit.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if;

    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        IRWrite;
    logic [31:0] PC;
    logic [31:0] ALUOut;
    logic [31:0] RegB;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic [31:0] Instruction;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [31:0] MDR;
    logic        Stall;
    logic        bus_err;

    modport slave (
        input  MemRead, MemWrite, IorD, IRWrite, PC, ALUOut, RegB,
        input  mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output Instruction, OpCode, Funct, MDR, Stall, bus_err
    );

    modport master (
        output MemRead, MemWrite, IorD, IRWrite, PC, ALUOut, RegB,
        output mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  Instruction, OpCode, Funct, MDR, Stall, bus_err
    );

endinterface
`default_nettype wire

// File: rtl/access_timer.sv
`default_nettype none
// ============================================================================
// Module      : access_timer
// Description : Counts request cycles without acknowledge and flags the cycle
//               in which the count reaches TIMEOUT.
// Revision    : 1.0  initial release
// ============================================================================
module access_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int C_CNT_W = $clog2(TIMEOUT + 1);

    logic [C_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted in the cycle whose increment brings the count to TIMEOUT.
    assign expired = enable && (r_count == C_CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Turns controller memory controls into single req/ack bus
//               transactions and captures read data into IR and MDR.
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] IR_RESET = C_IR_RESET
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);

    state_t      r_state,     w_state_nxt;
    logic        r_mem_req,   w_mem_req_nxt;
    logic        r_mem_we,    w_mem_we_nxt;
    logic [31:0] r_mem_addr,  w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic        r_ir_cap,    w_ir_cap_nxt;
    logic [31:0] r_ir,        w_ir_nxt;
    logic [31:0] r_mdr,       w_mdr_nxt;
    logic        r_bus_err,   w_bus_err_nxt;

    logic        w_ctl_req;
    logic [31:0] w_addr;
    logic        w_misaligned;
    logic        w_tmr_clear;
    logic        w_tmr_enable;
    logic        w_tmr_expired;

    assign w_ctl_req    = bus.MemRead | bus.MemWrite;
    assign w_addr       = bus.IorD ? bus.ALUOut : bus.PC;
    assign w_misaligned = |w_addr[1:0];

    assign w_tmr_clear  = (r_state == ST_IDLE) && w_ctl_req && !w_misaligned;
    assign w_tmr_enable = (r_state == ST_REQ) && !bus.mem_ack;

    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_access_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_tmr_clear),
        .enable  (w_tmr_enable),
        .expired (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ir_cap    <= 1'b0;
            r_ir        <= IR_RESET;
            r_mdr       <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_ir_cap    <= w_ir_cap_nxt;
            r_ir        <= w_ir_nxt;
            r_mdr       <= w_mdr_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_ir_cap_nxt    = r_ir_cap;
        w_ir_nxt        = r_ir;
        w_mdr_nxt       = r_mdr;
        w_bus_err_nxt   = r_bus_err;

        case (r_state)
            ST_IDLE: begin
                if (w_ctl_req) begin
                    if (w_misaligned) begin
                        w_bus_err_nxt = 1'b1;
                        w_state_nxt   = ST_ERR;
                    end else begin
                        // A simultaneous read and write is executed as a write.
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = bus.MemWrite;
                        w_mem_addr_nxt  = w_addr;
                        w_mem_wdata_nxt = bus.RegB;
                        w_ir_cap_nxt    = bus.IRWrite & bus.MemRead & ~bus.MemWrite;
                        w_state_nxt     = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (bus.mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    if (!r_mem_we) begin
                        w_mdr_nxt = bus.mem_rdata;
                        if (r_ir_cap) begin
                            w_ir_nxt = bus.mem_rdata;
                        end
                    end
                    w_state_nxt = ST_DONE;
                end else if (w_tmr_expired) begin
                    w_mem_req_nxt = 1'b0;
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = ST_ERR;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.Instruction = r_ir;
    assign bus.OpCode      = opcode_of(r_ir);
    assign bus.Funct       = funct_of(r_ir);
    assign bus.MDR         = r_mdr;
    assign bus.bus_err     = r_bus_err;
    assign bus.Stall       = reset & (((r_state == ST_IDLE) & w_ctl_req) | (r_state == ST_REQ));

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed scoreboard bench for mem_access_unit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset;

    mem_access_unit_if bus();

    mem_access_unit #(
        .TIMEOUT  (64),
        .IR_RESET (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] ir;
        logic [31:0] mdr;
    } txn_t;

    txn_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        post_pending = 1'b0;
    logic [31:0] post_ir;
    logic [31:0] post_mdr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [31:0] ir, input logic [31:0] mdr);
        txn_t t;
        t.addr = addr; t.we = we; t.wdata = wdata; t.ir = ir; t.mdr = mdr;
        exp_q.push_back(t);
    endtask

    task automatic set_ctl(input logic rd, input logic wr, input logic iord, input logic irw,
                           input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] regb);
        bus.MemRead = rd; bus.MemWrite = wr; bus.IorD = iord; bus.IRWrite = irw;
        bus.PC = pc; bus.ALUOut = alu; bus.RegB = regb;
    endtask

    task automatic clear_ctl();
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.IorD = 1'b0; bus.IRWrite = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Controls are set by the caller in cycle 0; ack is given in REQ cycle ack_cycle.
    task automatic do_access(input int ack_cycle, input logic [31:0] rdata, output int stall_cnt);
        stall_cnt = 0;
        @(negedge clk);
        if (bus.Stall) stall_cnt++;
        for (int c = 1; c <= ack_cycle; c++) begin
            step();
            if (c == ack_cycle) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
            end
            @(negedge clk);
            if (bus.Stall) stall_cnt++;
        end
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        if (bus.Stall) stall_cnt++;
        step();
        clear_ctl();
        @(negedge clk);
        check("no_req_from_done", 32'(bus.mem_req), 0);
    endtask

    initial begin : monitor
        txn_t t;
        forever begin
            @(negedge clk);
            if (post_pending) begin
                check("ir_after_ack", bus.Instruction, post_ir);
                check("mdr_after_ack", bus.MDR, post_mdr);
                check("done_stall", 32'(bus.Stall), 0);
                post_pending = 1'b0;
            end
            if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_txn actual_addr=0x%08h required=none", bus.mem_addr);
                end else begin
                    t = exp_q.pop_front();
                    check("txn_addr", bus.mem_addr, t.addr);
                    check("txn_we", 32'(bus.mem_we), 32'(t.we));
                    check("txn_wdata", bus.mem_wdata, t.wdata);
                    post_ir      = t.ir;
                    post_mdr     = t.mdr;
                    post_pending = 1'b1;
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        reset         = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_instruction", bus.Instruction, 32'h0000_0000);
        check("rst_mdr", bus.MDR, 0);
        check("rst_bus_err", 32'(bus.bus_err), 0);
        check("rst_stall", 32'(bus.Stall), 0);
        step();
        clear_ctl();
        reset = 1'b1;
        step();

        // Instruction fetch, ack in third REQ cycle
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h5555);
        push(32'h40, 1'b0, 32'h5555, 32'h8C22_0004, 32'h8C22_0004);
        do_access(3, 32'h8C22_0004, n);
        check("fetch_stall_cycles", n, 4);
        check("fetch_opcode", 32'(bus.OpCode), 32'h23);

        // Store, minimum latency
        step();
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h100, 32'hDEAD);
        push(32'h100, 1'b1, 32'hDEAD, 32'h8C22_0004, 32'h8C22_0004);
        do_access(1, 32'hFFFF_0000, n);
        check("store_stall_cycles", n, 2);

        // Data load, IR untouched
        step();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h104, 32'h0);
        push(32'h104, 1'b0, 32'h0, 32'h8C22_0004, 32'h0000_1234);
        do_access(2, 32'h0000_1234, n);
        check("load_stall_cycles", n, 3);

        // Read and write together behaves as a write
        step();
        set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 32'h44, 32'h200, 32'hCAFE_F00D);
        push(32'h200, 1'b1, 32'hCAFE_F00D, 32'h8C22_0004, 32'h0000_1234);
        do_access(1, 32'h1111_1111, n);

        // Second fetch, R-type add
        step();
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h0);
        push(32'h44, 1'b0, 32'h0, 32'h0085_1020, 32'h0085_1020);
        do_access(1, 32'h0085_1020, n);
        check("fetch2_opcode", 32'(bus.OpCode), 32'h00);
        check("fetch2_funct", 32'(bus.Funct), 32'h20);

        // Ack while idle is ignored
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        check("idle_ack_no_req", 32'(bus.mem_req), 0);
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_mdr", bus.MDR, 32'h0085_1020);
        check("idle_ack_ir", bus.Instruction, 32'h0085_1020);

        // Ack in the same cycle the timeout would expire
        step();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h300, 32'h0);
        push(32'h300, 1'b0, 32'h0, 32'h0085_1020, 32'hA5A5_A5A5);
        do_access(64, 32'hA5A5_A5A5, n);
        check("ack_at_timeout_stall", n, 65);
        check("ack_at_timeout_err", 32'(bus.bus_err), 0);

        // Reset during the second REQ cycle
        step();
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("stall_in_reset", 32'(bus.Stall), 0);
        step();
        clear_ctl();
        @(negedge clk);
        check("midreq_rst_req", 32'(bus.mem_req), 0);
        check("midreq_rst_ir", bus.Instruction, 32'h0000_0000);
        check("midreq_rst_mdr", bus.MDR, 0);
        step();
        reset = 1'b1;
        step();
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h9999_9999;
        @(negedge clk);
        check("late_ack_no_req", 32'(bus.mem_req), 0);
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_ir", bus.Instruction, 32'h0000_0000);
        check("late_ack_mdr", bus.MDR, 0);

        // Misaligned data address
        step();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h102, 32'h0);
        @(negedge clk);
        check("misalign_stall_c0", 32'(bus.Stall), 1);
        step();
        @(negedge clk);
        check("misalign_no_req", 32'(bus.mem_req), 0);
        check("misalign_bus_err", 32'(bus.bus_err), 1);
        check("misalign_stall_err", 32'(bus.Stall), 0);
        step();
        clear_ctl();
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        check("err_cleared_by_reset", 32'(bus.bus_err), 0);

        // No ack at all: timeout
        step();
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h50, 32'h0, 32'h0);
        n = 0;
        for (int c = 1; c <= 100; c++) begin
            step();
            @(negedge clk);
            if (bus.mem_req) n++;
            else break;
        end
        check("timeout_req_cycles", n, 64);
        check("timeout_addr", bus.mem_addr, 32'h50);
        check("timeout_bus_err", 32'(bus.bus_err), 1);
        check("timeout_stall", 32'(bus.Stall), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.mem_ack   = (i == 1);
            bus.mem_rdata = 32'h4242_4242;
            @(negedge clk);
            check("err_no_new_req", 32'(bus.mem_req), 0);
        end
        bus.mem_ack = 1'b0;
        check("err_mdr_frozen", bus.MDR, 0);
        check("err_ir_frozen", bus.Instruction, 32'h0000_0000);
        check("err_sticky", 32'(bus.bus_err), 1);

        clear_ctl();
        step();
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
